barrel_shift_cmd_queue: RTL and testbench



---
 rtl/barrel_shift_cmd_queue.sv | 103 ++++++++++
 tb/tb_barrel_shift_cmd_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_cmd_queue.sv
// Command FIFO in front of a combinational 4-bit barrel shifter, plus a
// registered result stage with valid/ready, turning the shifter into a
// flow-controlled pipeline stage.
module barrel_shift_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_select,
  input  logic                   in_direction,
  input  logic [1:0]             in_shift_value,
  input  logic [3:0]             in_din,
  output logic                   sh_select,
  output logic                   sh_direction,
  output logic [1:0]             sh_shift_value,
  output logic [3:0]             sh_din,
  input  logic [3:0]             sh_dout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // Entry layout: {select, direction, shift_value[1:0], din[3:0]}
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [3:0]    out_data_q, out_data_d;
  logic          push, pop;
  logic [7:0]    head;

  // Ready depends only on occupancy so a full queue refuses even when popping.
  assign in_ready = (count_q < FULL);
  assign push     = in_valid & in_ready;
  assign pop      = (count_q != '0) & (~out_valid_q | out_ready);

  // Head command is presented straight from storage; zeros when empty.
  assign head = (count_q != '0) ? mem_q[rptr_q] : 8'h00;
  assign {sh_select, sh_direction, sh_shift_value, sh_din} = head;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

  // Next-state: flush wins over any push/pop in the same cycle.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (clr) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_data_d  = 4'h0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop) begin
        rptr_d      = rptr_q + 1'b1;
        out_data_d  = sh_dout;
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Control and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 4'h0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Command storage; contents are only meaningful under count, so no reset.
  always_ff @(posedge clk) begin
    if (push && !clr)
      mem_q[wptr_q] <= {in_select, in_direction, in_shift_value, in_din};
  end

endmodule

// File: tb/tb_barrel_shift_cmd_queue.sv
// Bench for barrel_shift_cmd_queue: acts as the shifter itself and keeps a
// queue-based reference of accepted commands and the held result.
module tb_barrel_shift_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_ready;
  logic       in_select, in_direction;
  logic [1:0] in_shift_value;
  logic [3:0] in_din;
  logic       sh_select, sh_direction;
  logic [1:0] sh_shift_value;
  logic [3:0] sh_din, sh_dout;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_q[$];
  bit         m_hv;
  logic [3:0] m_hd;

  barrel_shift_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_select(in_select), .in_direction(in_direction),
    .in_shift_value(in_shift_value), .in_din(in_din),
    .sh_select(sh_select), .sh_direction(sh_direction),
    .sh_shift_value(sh_shift_value), .sh_din(sh_din),
    .sh_dout(sh_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  // Reference 4-bit barrel shifter on a packed command.
  function automatic logic [3:0] shf(input logic [7:0] c);
    logic [7:0] dd;
    int n;
    n  = int'(c[5:4]);
    dd = {c[3:0], c[3:0]};
    if (!c[7]) return c[6] ? 4'((c[3:0] << n)) : 4'((c[3:0] >> n));
    if (c[6]) begin
      dd = dd << n;
      return dd[7:4];
    end
    dd = dd >> n;
    return dd[3:0];
  endfunction

  always_comb sh_dout = shf({sh_select, sh_direction, sh_shift_value, sh_din});

  function automatic logic [7:0] rcmd();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_hv = 0;
    m_hd = 4'h0;
  endtask

  // Drive one cycle of inputs, advance one edge, and advance the reference.
  task automatic tick(input bit v, input logic [7:0] c, input bit ordy, input bit cl);
    bit pu, po;
    in_valid = v;
    {in_select, in_direction, in_shift_value, in_din} = c;
    out_ready = ordy;
    clr = cl;
    pu = v && (m_q.size() < DEPTH);
    po = (m_q.size() != 0) && (!m_hv || ordy);
    @(posedge clk);
    #1;
    if (cl) begin
      model_reset();
    end else begin
      if (po) begin
        m_hd = shf(m_q.pop_front());
        m_hv = 1;
      end else if (m_hv && ordy) begin
        m_hv = 0;
      end
      if (pu) m_q.push_back(c);
    end
    in_valid = 0;
    clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; clr = 0; in_valid = 0; out_ready = 0;
    {in_select, in_direction, in_shift_value, in_din} = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if ({sh_select, sh_direction, sh_shift_value, sh_din} !== 8'h00) begin
      errors++; $display("FAIL reset_sh got %h exp 00", {sh_select, sh_direction, sh_shift_value, sh_din});
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  // Rotate-left-by-1 of 1011 must appear on sh_* then emerge as 0111.
  task automatic test_latency(input string tag);
    tick(1, 8'b1101_1011, 1, 0);
    checks++; if ({sh_select, sh_direction, sh_shift_value, sh_din} !== 8'b1101_1011) begin
      errors++; $display("FAIL %s_sh got %h exp db", tag, {sh_select, sh_direction, sh_shift_value, sh_din});
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got %b exp 0", tag, out_valid); end
    tick(0, 8'h00, 1, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b0111) begin
      errors++; $display("FAIL %s_result got v=%b d=%b exp v=1 d=0111", tag, out_valid, out_data);
    end
    tick(0, 8'h00, 1, 0);
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL %s_drain got v=%b cnt=%0d exp v=0 cnt=0", tag, out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cmds [4] = '{8'b0010_1011, 8'b0111_1011, 8'b1001_1011, 8'b0100_0110};
    logic [3:0] exp  [4] = '{4'b0010, 4'b1000, 4'b1101, 4'b0110};
    logic [3:0] got[$];
    int cyc[$];
    for (int i = 0; i < 8; i++) begin
      tick(i < 4, (i < 4) ? cmds[i] : 8'h00, 1, 0);
      if (out_valid) begin got.push_back(out_data); cyc.push_back(i); end
    end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL b2b_data[%0d] got %b exp %b", i, got[i], exp[i]); end
      if (i > 0) begin
        checks++; if (cyc[i] != cyc[i-1] + 1) begin
          errors++; $display("FAIL b2b_gap[%0d] got cycle %0d exp %0d", i, cyc[i], cyc[i-1] + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] cmds [6];
    logic [3:0] got[$];
    int acc = 0;
    for (int i = 0; i < 6; i++) cmds[i] = rcmd();
    for (int i = 0; i < 6; i++) begin
      if (in_ready) acc++;
      tick(1, cmds[i], 0, 0);
      if (i >= 1) begin
        checks++; if (out_valid !== 1'b1 || out_data !== shf(cmds[0])) begin
          errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, shf(cmds[0]));
        end
      end
      if (i == 4) begin
        checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_full got cnt=%0d rdy=%b exp cnt=4 rdy=0", count, in_ready);
        end
      end
    end
    checks++; if (acc != 5) begin errors++; $display("FAIL bp_accepted got %0d exp 5", acc); end
    for (int i = 0; i < 10; i++) begin
      if (out_valid) got.push_back(out_data);
      tick(0, 8'h00, 1, 0);
    end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL bp_drain_len got %0d exp 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++; if (got[i] !== shf(cmds[i])) begin
        errors++; $display("FAIL bp_order[%0d] got %h exp %h", i, got[i], shf(cmds[i]));
      end
    end
  endtask

  task automatic test_full_stream();
    for (int i = 0; i < 5; i++) tick(1, rcmd(), 0, 0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fs_refuse got rdy=%b exp 0", in_ready); end
    for (int i = 0; i < 24; i++) begin
      tick(1, rcmd(), 1, 0);
      checks++; if (count !== 3'(m_q.size()) || in_ready !== (m_q.size() < DEPTH)) begin
        errors++; $display("FAIL fs_occ[%0d] got cnt=%0d rdy=%b exp cnt=%0d", i, count, in_ready, m_q.size());
      end
      checks++; if (out_valid !== m_hv || out_data !== m_hd) begin
        errors++; $display("FAIL fs_out[%0d] got v=%b d=%h exp v=%b d=%h", i, out_valid, out_data, m_hv, m_hd);
      end
    end
    for (int i = 0; i < 8; i++) tick(0, 8'h00, 1, 0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) tick(1, rcmd(), 0, 0);
    checks++; if (count !== 3'd3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL clr_pre got cnt=%0d v=%b exp cnt=3 v=1", count, out_valid);
    end
    tick(1, rcmd(), 0, 1);
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 4'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL clr_post got cnt=%0d v=%b d=%h rdy=%b exp 0 0 0 1", count, out_valid, out_data, in_ready);
    end
    tick(0, 8'h00, 1, 0);
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL clr_dropped got cnt=%0d v=%b exp cnt=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) tick(1, rcmd(), 0, 0);
    in_valid = 1;
    #2;
    rst_n = 0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 4'h0 || in_ready !== 1'b1
                  || {sh_select, sh_direction, sh_shift_value, sh_din} !== 8'h00) begin
      errors++; $display("FAIL arst_now got cnt=%0d v=%b d=%h rdy=%b", count, out_valid, out_data, in_ready);
    end
    in_valid = 0;
    model_reset();
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
    test_latency("arst_lat");
  endtask

  task automatic test_random();
    logic [7:0] hd;
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, rcmd(), $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      hd = (m_q.size() != 0) ? m_q[0] : 8'h00;
      checks++; if (count !== 3'(m_q.size()) || in_ready !== (m_q.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_occ[%0d] got cnt=%0d rdy=%b exp cnt=%0d", i, count, in_ready, m_q.size());
      end
      checks++; if (out_valid !== m_hv || out_data !== m_hd) begin
        errors++; $display("FAIL rnd_out[%0d] got v=%b d=%h exp v=%b d=%h", i, out_valid, out_data, m_hv, m_hd);
      end
      checks++; if ({sh_select, sh_direction, sh_shift_value, sh_din} !== hd) begin
        errors++; $display("FAIL rnd_sh[%0d] got %h exp %h", i, {sh_select, sh_direction, sh_shift_value, sh_din}, hd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency("lat");
    test_back_to_back();
    test_backpressure();
    test_full_stream();
    test_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
